ccff_loader: RTL
================

CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 64: number of configuration flops in the downstream ccff chain (legal range 1..65535).
REQ-002 SHALL have parameter IDXW, default $clog2(CHAIN_LEN+1): width of the bit counter and error index.
REQ-003 prog_clk  in  1  single clock; all state updates on its rising edge.
REQ-004 prog_reset  in  1  reset, synchronous and active-high.
REQ-005 start  in  1  pulse that begins a load; honoured only in IDLE or DONE.
REQ-006 verify_en  in  1  sampled with start; 1 = load pass followed by verify pass.
REQ-007 bs_data  in  8  bitstream byte, MSB shifted first.
REQ-008 bs_valid  in  1  bs_data valid.
REQ-009 bs_ready  out  1  loader accepts a byte this cycle.
REQ-010 ccff_head  out  1  serial config bit to the chain head.
REQ-011 ccff_shift_en  out  1  chain advances one bit at a prog_clk edge only when 1 (downstream prog_clk gate enable).
REQ-012 ccff_tail  in  1  chain tail output, returned for verify.
REQ-013 busy  out  1  high in LOAD or VERIFY.
REQ-014 done  out  1  high in DONE.
REQ-015 verify_err  out  1  sticky mismatch flag.
REQ-016 err_index  out  IDXW  bit index (0-based, within the pass) of the first mismatch.

Function
REQ-017 SHALL implement states IDLE, LOAD, VERIFY, DONE.
REQ-018 IDLE/DONE + start -> LOAD: clear bit counter, clear the byte buffer, clear verify_err and err_index, latch verify_en.
REQ-019 LOAD: when bit counter reaches CHAIN_LEN -> VERIFY if latched verify_en, else DONE; counter cleared on the transition.
REQ-020 VERIFY: when bit counter reaches CHAIN_LEN -> DONE.
REQ-021 start while busy SHALL be ignored.
REQ-022 Byte buffer: 8-bit shift register plus bit-remaining count; bs_ready = busy AND buffer empty, registered.
REQ-023 A byte is accepted on a cycle where bs_valid AND bs_ready; bs_ready SHALL be 0 in the following cycle.
REQ-024 A byte accepted in cycle t SHALL have bit7 on ccff_head with ccff_shift_en=1 in cycle t+1, through bit0 in cycle t+8; bs_ready=1 again in cycle t+9 if still busy.
REQ-025 ccff_shift_en SHALL be 1 only while a buffered bit is presented and the pass bit counter is below CHAIN_LEN; the bit counter increments by 1 on each such cycle.
REQ-026 When a pass completes mid-byte, the remaining bits of that byte SHALL be discarded, never shifted, and not carried into the next pass; the next pass starts on a fresh byte.
REQ-027 Buffer starvation (bs_valid low) SHALL hold ccff_shift_en=0 and ccff_head=0, with no counter change.
REQ-028 In VERIFY, on each ccff_shift_en cycle the loader SHALL compare ccff_tail with ccff_head; on the first mismatch, set verify_err=1 and err_index=current bit counter; later mismatches leave err_index unchanged.
REQ-029 In VERIFY, the host SHALL resend the identical bitstream; ccff_tail then presents first-pass bit k while second-pass bit k is shifted.
REQ-030 verify_err and err_index SHALL hold through DONE until the next accepted start or reset.
REQ-031 done SHALL remain 1 in DONE until start or reset.

Reset
REQ-032 prog_reset=1 at an edge SHALL force IDLE with all outputs 0 (bs_ready, ccff_head, ccff_shift_en, busy, done, verify_err, err_index), the counters cleared and the buffer emptied.
REQ-033 Reset mid-LOAD/VERIFY SHALL abort immediately, so no ccff_shift_en pulse follows the reset edge; chain contents are then undefined and a full reload is required.

Verification (CHAIN_LEN=10; the bench models a 10-flop chain enabled by ccff_shift_en)
REQ-034 start, verify_en=0, bytes 0xA5,0xC0 -> ccff_head on shift cycles 1,0,1,0,0,1,0,1,1,1; exactly 10 ccff_shift_en cycles; done=1; model chain = 1010010111; byte 2 bits 5..0 never shifted.
REQ-035 verify_en=1, bytes A5,C0,A5,C0 -> 20 shifts; verify_err=0; done=1.
REQ-036 verify_en=1, second pass bytes A5,80 -> verify_err=1, err_index=9; done=1.
REQ-037 bs_valid dropped for 5 cycles mid-byte boundary -> ccff_shift_en=0 for those cycles; final chain content identical to REQ-034.
REQ-038 prog_reset asserted after 4 shifts -> next cycle busy=0, ccff_shift_en=0, bs_ready=0; following start reloads 10 bits from bit 0.
REQ-039 start pulsed during LOAD -> ignored; shift count and sequence unchanged; start in DONE -> new LOAD with verify_err cleared.

Source files
------------

// File: rtl/ccff_loader.sv
// Configuration-chain loader: takes a byte-wide bitstream and shifts it MSB-first
// into a CHAIN_LEN-flop ccff chain. An optional verify pass re-shifts the same
// stream and compares the chain tail against it, flagging the first mismatch.
module ccff_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int IDXW      = $clog2(CHAIN_LEN + 1)
) (
    input  logic            prog_clk,
    input  logic            prog_reset,
    input  logic            start,
    input  logic            verify_en,
    input  logic [7:0]      bs_data,
    input  logic            bs_valid,
    output logic            bs_ready,
    output logic            ccff_head,
    output logic            ccff_shift_en,
    input  logic            ccff_tail,
    output logic            busy,
    output logic            done,
    output logic            verify_err,
    output logic [IDXW-1:0] err_index
);

    typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;

    localparam logic [IDXW-1:0] LEN  = IDXW'(CHAIN_LEN);
    localparam logic [IDXW-1:0] LAST = IDXW'(CHAIN_LEN - 1);

    state_t          state, state_next;
    logic [IDXW-1:0] bit_cnt;
    logic [7:0]      buf_sreg;
    logic [3:0]      buf_rem, buf_rem_next;
    logic            verify_lat;
    logic            start_ok, accept, pass_end, busy_next;

    // A new load is only honoured when no pass is in progress.
    assign start_ok      = start && (state == IDLE || state == DONE);
    assign busy          = (state == LOAD) || (state == VERIFY);
    assign done          = (state == DONE);
    assign accept        = bs_valid && bs_ready;
    assign ccff_shift_en = busy && (buf_rem != 4'd0) && (bit_cnt < LEN);
    assign ccff_head     = ccff_shift_en && buf_sreg[7];
    // The last bit of a pass completes on this shift; the transition happens on
    // the same edge so the counter never sits idle at CHAIN_LEN.
    assign pass_end      = ccff_shift_en && (bit_cnt == LAST);
    assign busy_next     = (state_next == LOAD) || (state_next == VERIFY);

    // State register.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: passes end when the bit counter reaches CHAIN_LEN.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start) state_next = LOAD;
            LOAD:       if (pass_end) state_next = verify_lat ? VERIFY : DONE;
            VERIFY:     if (pass_end) state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    // Bits left in the byte buffer; a pass boundary drops any leftover bits.
    always_comb begin
        buf_rem_next = buf_rem;
        if (start_ok || pass_end) begin
            buf_rem_next = 4'd0;
        end else if (ccff_shift_en) begin
            buf_rem_next = buf_rem - 4'd1;
        end else if (accept) begin
            buf_rem_next = 4'd8;
        end
    end

    // Bit counter, buffer, ready handshake and sticky verify result.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            bit_cnt    <= '0;
            buf_rem    <= 4'd0;
            bs_ready   <= 1'b0;
            verify_err <= 1'b0;
            err_index  <= '0;
            verify_lat <= 1'b0;
        end else begin
            buf_rem  <= buf_rem_next;
            bs_ready <= busy_next && (buf_rem_next == 4'd0);
            if (start_ok) begin
                bit_cnt    <= '0;
                verify_err <= 1'b0;
                err_index  <= '0;
                verify_lat <= verify_en;
            end else begin
                if (pass_end) begin
                    bit_cnt <= '0;
                end else if (ccff_shift_en) begin
                    bit_cnt <= bit_cnt + IDXW'(1);
                end
                if (state == VERIFY && ccff_shift_en && (ccff_tail != ccff_head) && !verify_err) begin
                    verify_err <= 1'b1;
                    err_index  <= bit_cnt;
                end
            end
        end
    end

    // Byte shift register; data only, so it carries no reset.
    always_ff @(posedge prog_clk) begin
        if (ccff_shift_en) begin
            buf_sreg <= {buf_sreg[6:0], 1'b0};
        end else if (accept) begin
            buf_sreg <= bs_data;
        end
    end

endmodule
